// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate vector checker.
//  - Bit positions of the eight gate outputs inside gate_out.
//  - Checker FSM state encoding.
//  - exp_gates(): golden response of the two-input gate block.
`timescale 1ns/1ps
package gate_chk_pkg;

  localparam int GATE_W = 8;

  // gate_out layout: {notb,nota,xnor,xor,nor,nand,or,and}
  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NAND_B = 2;
  localparam int NOR_B  = 3;
  localparam int XOR_B  = 4;
  localparam int XNOR_B = 5;
  localparam int NOTA_B = 6;
  localparam int NOTB_B = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } chk_state_e;

  function automatic logic [GATE_W-1:0] exp_gates(input logic a, input logic b);
    logic [GATE_W-1:0] g;
    g         = '0;
    g[AND_B]  = a & b;
    g[OR_B]   = a | b;
    g[NAND_B] = ~(a & b);
    g[NOR_B]  = ~(a | b);
    g[XOR_B]  = a ^ b;
    g[XNOR_B] = ~(a ^ b);
    g[NOTA_B] = ~a;
    g[NOTB_B] = ~b;
    return g;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden model of the two-input basic-gate block.
// Ports:
//  a_i, b_i  in  1  current stimulus vector
//  exp_o     out 8  expected {notb,nota,xnor,xor,nor,nand,or,and}
`timescale 1ns/1ps
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [GATE_W-1:0] exp_o
);

  assign exp_o = exp_gates(a_i, b_i);

endmodule

// File: rtl/gate_vector_checker.sv
// Clocked stimulus/response checker for the two-input basic-gate block.
// Sweeps {a,b} through 00,01,10,11 NUM_PASSES times, samples gate_out
// SETTLE_CYCLES cycles after each drive, compares against the golden model,
// and reports a saturating mismatch count plus the first failing vector.
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// only while the FSM is IDLE (busy=0 and done=0) and silently dropped
// otherwise. done is a one-cycle completion pulse; pass/err_count/fail_vec/
// fail_bits stay valid from done until the next accepted start.
//
// Ports:
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      run request pulse
//  a, b       out  1      stimulus to the gate block
//  gate_out   in   8      gate block response
//  busy       out  1      run in progress
//  done       out  1      end-of-run pulse
//  pass       out  1      run had no mismatches
//  err_count  out  ERR_W  mismatching vectors, saturating
//  fail_vec   out  2      {a,b} of first failing vector
//  fail_bits  out  8      expected ^ actual of first failing vector
//  dbg_state  out  3      current FSM state
`timescale 1ns/1ps
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a,
  output logic              b,
  input  logic [GATE_W-1:0] gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        fail_vec,
  output logic [GATE_W-1:0] fail_bits,
  output chk_state_e        dbg_state
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = $clog2(NUM_PASSES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  chk_state_e         state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [1:0]         fail_vec_q, fail_vec_d;
  logic [GATE_W-1:0]  fail_bits_q, fail_bits_d;
  logic               first_seen_q, first_seen_d;
  logic               pass_q, pass_d;

  logic [GATE_W-1:0]  exp_vec;
  logic [GATE_W-1:0]  diff;
  logic               mismatch;

  gate_golden_model u_golden (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_vec)
  );

  assign diff = exp_vec ^ gate_out;
  // Case inequality so an X/Z anywhere on gate_out is a mismatch.
  assign mismatch = (gate_out !== exp_vec);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    pass_cnt_d   = pass_cnt_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_bits_d  = fail_bits_q;
    first_seen_d = first_seen_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          vec_d        = 2'b00;
          pass_cnt_d   = '0;
          err_d        = '0;
          fail_vec_d   = 2'b00;
          fail_bits_d  = '0;
          first_seen_d = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_DRIVE: begin
        a_d   = vec_q[1];
        b_d   = vec_q[0];
        cnt_d = SETTLE_LOAD;
        // a/b change on this edge and are sampled at the end of SAMPLE,
        // so SETTLE only needs SETTLE_CYCLES-1 cycles of its own.
        if (SETTLE_CYCLES > 1) state_d = ST_SETTLE;
        else                   state_d = ST_SAMPLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!first_seen_q) begin
            first_seen_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_bits_d  = diff;
          end
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        vec_d   = vec_q + 2'd1;
        state_d = ST_DRIVE;
        if (vec_q == 2'b11) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          if (pass_cnt_q == PASS_LAST) begin
            state_d = ST_DONE;
            pass_d  = (err_q == '0);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= 2'b00;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      cnt_q        <= '0;
      pass_cnt_q   <= '0;
      err_q        <= '0;
      fail_vec_q   <= 2'b00;
      fail_bits_q  <= '0;
      first_seen_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_bits_q  <= fail_bits_d;
      first_seen_q <= first_seen_d;
      pass_q       <= pass_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                     (state_q == ST_SAMPLE) || (state_q == ST_NEXT);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_bits = fail_bits_q;
  assign dbg_state = state_q;

endmodule
